// File: rtl/red_seq.sv
// ---------------------------------------------------------------------------
// red_seq -- multi-cycle sequencer for the ALU's 16-bit reduction (RED) op.
//
// The two operands are treated as four signed bytes. One shared 10-bit adder
// is used three times:
//   LOW  : pL = sext(aL) + sext(bL)          (9-bit partial)
//   HIGH : pH = sext(aH) + sext(bH)          (9-bit partial)
//   FIN  : R  = sext(pL) + sext(pH)          (10-bit, range -512..508)
// The result is sign-extended to 16 bits, registered into Sum, and flagged
// with a one-cycle done pulse.
//
// Ports:
//   clk    in   1   core clock, rising edge
//   rst_n  in   1   asynchronous active-low reset; clears all state
//   start  in   1   request, only looked at while IDLE
//   abort  in   1   synchronous flush back to IDLE, no done; beats start
//   A      in  16   operand 1 {aH, aL}, latched when start is accepted
//   B      in  16   operand 2 {bH, bL}, latched when start is accepted
//   busy   out  1   high whenever the sequencer is not IDLE
//   done   out  1   one-cycle pulse; Sum is valid from this cycle on
//   Sum    out 16   registered result, held until the next done
// ---------------------------------------------------------------------------
module red_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  input  logic [15:0] A,
  input  logic [15:0] B,
  output logic        busy,
  output logic        done,
  output logic [15:0] Sum
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2,
    FIN  = 2'd3
  } state_t;

  state_t      state;
  state_t      state_nxt;

  // Latched operands: the pipeline is free to change A/B after acceptance.
  logic [15:0] a_q;
  logic [15:0] b_q;

  // Partial sums; 9 bits each since two signed bytes never overflow 9 bits.
  logic [8:0]  p_low;
  logic [8:0]  p_high;

  logic        done_q;
  logic [15:0] sum_q;

  // Shared adder and its per-state operand selection.
  logic [9:0]  add_x;
  logic [9:0]  add_y;
  logic [9:0]  add_s;

  // Register-load strobes decoded from the current state.
  logic        ld_ops;
  logic        ld_low;
  logic        ld_high;
  logic        ld_sum;

  // -------------------------------------------------------------------------
  // Next-state and datapath control
  // -------------------------------------------------------------------------
  // NOTE: every signal gets a default before the case statement; a path that
  // left one unassigned would make synthesis infer a latch to hold it.
  always_comb begin
    state_nxt = state;
    add_x     = '0;
    add_y     = '0;
    ld_ops    = 1'b0;
    ld_low    = 1'b0;
    ld_high   = 1'b0;
    ld_sum    = 1'b0;

    unique case (state)
      IDLE: begin
        if (start) begin
          state_nxt = LOW;
          ld_ops    = 1'b1;
        end
      end

      LOW: begin
        add_x     = {{2{a_q[7]}}, a_q[7:0]};
        add_y     = {{2{b_q[7]}}, b_q[7:0]};
        ld_low    = 1'b1;
        state_nxt = HIGH;
      end

      HIGH: begin
        add_x     = {{2{a_q[15]}}, a_q[15:8]};
        add_y     = {{2{b_q[15]}}, b_q[15:8]};
        ld_high   = 1'b1;
        state_nxt = FIN;
      end

      FIN: begin
        add_x     = {p_low[8], p_low};
        add_y     = {p_high[8], p_high};
        ld_sum    = 1'b1;
        state_nxt = IDLE;
      end

      default: state_nxt = IDLE;
    endcase

    // abort wins over everything, including a start seen in IDLE: no load,
    // no result update, straight back to IDLE.
    if (abort) begin
      state_nxt = IDLE;
      ld_ops    = 1'b0;
      ld_low    = 1'b0;
      ld_high   = 1'b0;
      ld_sum    = 1'b0;
    end
  end

  assign add_s = add_x + add_y;

  // -------------------------------------------------------------------------
  // State and datapath registers
  // -------------------------------------------------------------------------
  // NOTE: clocked state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: operand and partial registers are reset too, so an aborted or
      // reset operation never leaves stale data visible after reset.
      state  <= IDLE;
      a_q    <= '0;
      b_q    <= '0;
      p_low  <= '0;
      p_high <= '0;
      done_q <= 1'b0;
      sum_q  <= '0;
    end else begin
      state  <= state_nxt;
      done_q <= ld_sum;

      if (ld_ops) begin
        a_q <= A;
        b_q <= B;
      end

      // The adder result fits in 9 bits for byte sums; bit 9 is a copy of
      // bit 8 and is dropped.
      if (ld_low)  p_low  <= add_s[8:0];
      if (ld_high) p_high <= add_s[8:0];

      if (ld_sum)  sum_q  <= {{6{add_s[9]}}, add_s};
    end
  end

  // busy is a pure decode of the state register, so no input reaches it
  // combinationally.
  assign busy = (state != IDLE);
  assign done = done_q;
  assign Sum  = sum_q;

endmodule

// File: tb/tb_red_seq.sv
// ---------------------------------------------------------------------------
// tb_red_seq -- self-checking bench for red_seq.
//
// Every started operation that should complete pushes its expected Sum into
// a queue; a monitor pops and compares on each done pulse. An unexpected
// done, a stretched done, or Sum moving outside a done cycle is flagged.
// Inputs are driven and outputs sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_red_seq;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [15:0] A     = '0;
  logic [15:0] B     = '0;
  logic        busy;
  logic        done;
  logic [15:0] Sum;

  int          n_checks  = 0;
  int          n_errors  = 0;
  int          cyc       = 0;
  int          n_done    = 0;
  logic        prev_done = 1'b0;
  logic [15:0] last_sum  = '0;
  logic [15:0] exp_q[$];

  red_seq dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .abort (abort),
    .A     (A),
    .B     (B),
    .busy  (busy),
    .done  (done),
    .Sum   (Sum)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)",
               tag, obs, exp, cyc);
    end
  endtask

  // Reference arithmetic: four signed bytes summed, result sign-extended.
  function automatic logic [15:0] model(input logic [15:0] a,
                                        input logic [15:0] b);
    byte al, ah, bl, bh;
    int  r;
    al = a[7:0];
    ah = a[15:8];
    bl = b[7:0];
    bh = b[15:8];
    r  = int'(al) + int'(bl) + int'(ah) + int'(bh);
    return r[15:0];
  endfunction

  // Scoreboard monitor.
  always @(negedge clk) begin
    if (!rst_n) begin
      last_sum = '0;
    end else if (done) begin
      n_done++;
      check("done_pulse_width", 32'(prev_done), 32'd0);
      if (exp_q.size() == 0) check("unexpected_done", 32'(done), 32'd0);
      else                   check("sum", 32'(Sum), 32'(exp_q.pop_front()));
      last_sum = Sum;
    end else begin
      check("sum_stable", 32'(Sum), 32'(last_sum));
    end
    prev_done = done;
  end

  // Call on a falling edge with the DUT idle (or in its done cycle). Returns
  // on the falling edge of the done cycle.
  task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] exp);
    int n  = 0;
    int nb = 0;
    start = 1'b1;
    A     = a;
    B     = b;
    exp_q.push_back(exp);
    @(negedge clk);
    start = 1'b0;
    A     = 16'($urandom);   // operands must already be latched
    B     = 16'($urandom);
    while (!done && n < 12) begin
      if (busy) nb++;
      n++;
      @(negedge clk);
    end
    check("latency", n, 3);
    check("busy_cycles", nb, 3);
    check("busy_in_done", 32'(busy), 32'd0);
  endtask

  initial begin
    int t1;
    int nd0;
    logic [15:0] ra, rb;

    // Reset state
    #12;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_sum",  32'(Sum),  32'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);

    // Basic and sign-extension cases
    run_op(16'h0102, 16'h0304, 16'h000A);
    @(negedge clk);
    run_op(16'hFFFF, 16'hFFFF, 16'hFFFC);
    @(negedge clk);
    run_op(16'h8080, 16'h8080, 16'hFE00);
    @(negedge clk);
    run_op(16'h7F7F, 16'h7F7F, 16'h01FC);

    // Back-to-back: start raised in the done cycle
    t1 = cyc;
    run_op(16'h0000, 16'h00FF, 16'hFFFF);
    check("b2b_spacing", cyc - t1, 4);

    // Start while busy is ignored, operand changes have no effect
    @(negedge clk);
    nd0   = n_done;
    start = 1'b1;
    A     = 16'h0101;
    B     = 16'h0101;
    exp_q.push_back(16'h0004);
    @(negedge clk);
    check("busy_after_start", 32'(busy), 32'd1);
    A = 16'h7F7F;
    B = 16'h7F7F;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    check("one_done_only", n_done - nd0, 1);

    // abort beats start in IDLE
    start = 1'b1;
    abort = 1'b1;
    A     = 16'h1234;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    check("abort_over_start", 32'(busy), 32'd0);

    // Abort in HIGH: no done, Sum holds
    nd0   = n_done;
    start = 1'b1;
    A     = 16'h1111;
    B     = 16'h2222;
    @(negedge clk);                 // LOW
    start = 1'b0;
    @(negedge clk);                 // HIGH
    check("busy_in_high", 32'(busy), 32'd1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_sum_hold", 32'(Sum), 32'h0004);
    repeat (6) @(negedge clk);
    check("abort_no_done", n_done - nd0, 0);
    run_op(16'h1234, 16'h5678, model(16'h1234, 16'h5678));

    // Random operands against the model
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      ra = 16'($urandom);
      rb = 16'($urandom);
      run_op(ra, rb, model(ra, rb));
    end

    // Reset in the middle of FIN
    @(negedge clk);
    run_op(16'h0102, 16'h0304, 16'h000A);
    @(negedge clk);
    nd0   = n_done;
    start = 1'b1;
    A     = 16'h0505;
    B     = 16'h0505;
    @(negedge clk);                 // LOW
    start = 1'b0;
    @(negedge clk);                 // HIGH
    @(negedge clk);                 // FIN
    check("busy_in_fin", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_sum",  32'(Sum),  32'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (8) @(negedge clk);
    check("midrst_no_done", n_done - nd0, 0);
    check("midrst_idle", 32'(busy), 32'd0);

    check("scoreboard_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

endmodule
